// File: rtl/gol_pkg.sv
// Shared defaults and types for the Game-of-Life generation scheduler.
package gol_pkg;

    localparam int DEF_WIDTH     = 100;
    localparam int DEF_HEIGHT    = 100;
    localparam int DEF_BLOCK_LEN = 4;
    localparam int ROW_AW        = $clog2(DEF_HEIGHT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD0,
        S_LOAD1,
        S_FILL,
        S_SCAN,
        S_WRITE,
        S_DONE
    } sched_state_t;

endpackage

// File: rtl/Evolution.sv
// Combinational Life rule over one BLOCK_LEN-wide, three-row block plus its left neighbour block.
// Zero latency; no flow control.
module Evolution
    import gol_pkg::*;
#(
    parameter int BLOCK_LEN = DEF_BLOCK_LEN
) (
    input  logic [3*BLOCK_LEN-1:0] line_status,
    input  logic [3*BLOCK_LEN-1:0] last_line_status,
    output logic [BLOCK_LEN-1:0]   now_live,
    output logic                   prev_live_single
);
    localparam int BL = BLOCK_LEN;
    localparam int EW = 2 * BL + 1;

    // Each row is {0, current block, previous block}; the top zero stands in for the unseen next block.
    logic [EW-1:0] up, mid, dn;

    assign up  = {1'b0, line_status[BL-1:0],      last_line_status[BL-1:0]};
    assign mid = {1'b0, line_status[2*BL-1:BL],   last_line_status[2*BL-1:BL]};
    assign dn  = {1'b0, line_status[3*BL-1:2*BL], last_line_status[3*BL-1:2*BL]};

    function automatic logic next_cell(input logic [EW-1:0] u, input logic [EW-1:0] m,
                                       input logic [EW-1:0] d, input int j);
        logic [3:0] n;
        n = 4'(u[j-1]) + 4'(u[j]) + 4'(u[j+1]) + 4'(m[j-1]) + 4'(m[j+1])
          + 4'(d[j-1]) + 4'(d[j]) + 4'(d[j+1]);
        return (n == 4'd3) || (m[j] && (n == 4'd2));
    endfunction

    for (genvar i = 0; i < BL; i++) begin : g_live
        assign now_live[i] = next_cell(up, mid, dn, BL + i);
    end

    assign prev_live_single = next_cell(up, mid, dn, BL - 1);

endmodule

// File: rtl/evolution_scheduler.sv
// Streams grid rows through a sliding three-row window and writes one next-state row per WRITE.
// One generation takes 4+HEIGHT*(NB+2) cycles from start; RAM reads have fixed 1-cycle latency, no backpressure.
module evolution_scheduler
    import gol_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int HEIGHT    = DEF_HEIGHT,
    parameter int BLOCK_LEN = DEF_BLOCK_LEN
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [15:0]               gen_count,
    output logic                      rd_en,
    output logic [$clog2(HEIGHT)-1:0] rd_addr,
    input  logic [WIDTH-1:0]          rd_data,
    output logic                      wr_en,
    output logic [$clog2(HEIGHT)-1:0] wr_addr,
    output logic [WIDTH-1:0]          wr_data
);
    localparam int BL = BLOCK_LEN;
    localparam int NB = WIDTH / BLOCK_LEN;
    localparam int RW = $clog2(HEIGHT);
    localparam int BW = $clog2(NB + 1);

    sched_state_t   state_q, state_d;
    logic [WIDTH-1:0] above_q, above_d;
    logic [WIDTH-1:0] cur_q, cur_d;
    logic [WIDTH-1:0] below_q, below_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] out_row_q, out_row_d;
    logic [RW-1:0]    r_q, r_d;
    logic [BW-1:0]    b_q, b_d;
    logic [15:0]      gen_q, gen_d;
    logic             rd_issued_q;

    logic [3*BL-1:0]  cur_blk, prev_blk;
    logic [BL-1:0]    now_live;
    logic             prev_live_single;
    logic [RW:0]      r_plus2;

    // Block NB (past the right edge) and block -1 (past the left edge) fall through as zeros.
    always_comb begin
        cur_blk  = '0;
        prev_blk = '0;
        for (int k = 0; k < NB; k++) begin
            if (b_q == BW'(k)) begin
                cur_blk = {below_q[k*BL +: BL], cur_q[k*BL +: BL], above_q[k*BL +: BL]};
            end
            if (b_q == BW'(k + 1)) begin
                prev_blk = {below_q[k*BL +: BL], cur_q[k*BL +: BL], above_q[k*BL +: BL]};
            end
        end
    end

    Evolution #(.BLOCK_LEN(BLOCK_LEN)) u_evolution (
        .line_status      (cur_blk),
        .last_line_status (prev_blk),
        .now_live         (now_live),
        .prev_live_single (prev_live_single)
    );

    assign r_plus2 = {1'b0, r_q} + (RW+1)'(2);

    always_comb begin
        state_d   = state_q;
        above_d   = above_q;
        cur_d     = cur_q;
        below_d   = below_q;
        pend_d    = pend_q;
        out_row_d = out_row_q;
        r_d       = r_q;
        b_d       = b_q;
        gen_d     = gen_q;
        rd_en     = 1'b0;
        rd_addr   = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD0;
            end
            S_LOAD0: begin
                rd_en   = 1'b1;
                state_d = S_LOAD1;
            end
            S_LOAD1: begin
                rd_en   = 1'b1;
                rd_addr = RW'(1);
                cur_d   = rd_data;
                above_d = '0;
                r_d     = '0;
                b_d     = '0;
                state_d = S_FILL;
            end
            S_FILL: begin
                below_d = rd_data;
                state_d = S_SCAN;
            end
            S_SCAN: begin
                for (int k = 0; k < NB; k++) begin
                    if (b_q == BW'(k)) out_row_d[k*BL +: BL-1] = now_live[BL-2:0];
                    if (b_q == BW'(k + 1)) out_row_d[k*BL+BL-1] = prev_live_single;
                end
                // The row two below is prefetched so it is ready to shift in at WRITE.
                if ((b_q == '0) && (r_plus2 < (RW+1)'(HEIGHT))) begin
                    rd_en   = 1'b1;
                    rd_addr = r_plus2[RW-1:0];
                end
                if (b_q == BW'(1)) pend_d = rd_issued_q ? rd_data : '0;
                if (b_q == BW'(NB)) state_d = S_WRITE;
                else                b_d     = b_q + BW'(1);
            end
            S_WRITE: begin
                wr_en   = 1'b1;
                wr_addr = r_q;
                above_d = cur_q;
                cur_d   = below_q;
                below_d = pend_q;
                b_d     = '0;
                if (r_q == RW'(HEIGHT - 1)) begin
                    state_d = S_DONE;
                end else begin
                    r_d     = r_q + RW'(1);
                    state_d = S_SCAN;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                gen_d   = gen_q + 16'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            above_q     <= '0;
            cur_q       <= '0;
            below_q     <= '0;
            pend_q      <= '0;
            out_row_q   <= '0;
            r_q         <= '0;
            b_q         <= '0;
            gen_q       <= '0;
            rd_issued_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            above_q     <= above_d;
            cur_q       <= cur_d;
            below_q     <= below_d;
            pend_q      <= pend_d;
            out_row_q   <= out_row_d;
            r_q         <= r_d;
            b_q         <= b_d;
            gen_q       <= gen_d;
            rd_issued_q <= rd_en;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign gen_count = gen_q;
    assign wr_data   = out_row_q;

endmodule

// File: tb/tb_evolution_scheduler.sv
// Directed bench: RAM model plus a scoreboard of golden next-state rows checked at every write.
module tb_evolution_scheduler;
    import gol_pkg::*;

    localparam int W  = DEF_WIDTH;
    localparam int H  = DEF_HEIGHT;
    localparam int AW = ROW_AW;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } wexp_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic [15:0]   gen_count;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;

    logic [W-1:0] mem [2][H];
    int           bank;
    wexp_t        wq[$];
    int           rd_exp;
    int           exp_gen;
    int           n_cmp;
    int           n_bad;

    evolution_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .gen_count (gen_count),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[bank][rd_addr];
        if (wr_en) mem[1-bank][wr_addr] <= wr_data;
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rd_en) begin
            check("rd_addr", W'(rd_addr), W'(rd_exp));
            rd_exp++;
        end
        if (wr_en) begin
            n_cmp++;
            assert (wq.size() > 0) else begin
                n_bad++;
                $error("FAIL wr_unexpected: observed write to row %0d expected none", wr_addr);
            end
            if (wq.size() > 0) begin
                wexp_t e;
                e = wq.pop_front();
                check("wr_addr", W'(wr_addr), W'(e.addr));
                check("wr_data", wr_data, e.data);
            end
        end
    end

    function automatic logic cell_at(int bk, int r, int c);
        if (r < 0 || r >= H || c < 0 || c >= W) return 1'b0;
        return mem[bk][r][c];
    endfunction

    task automatic prep_gen();
        logic [W-1:0] row;
        int           n;
        wexp_t        e;
        wq.delete();
        rd_exp = 0;
        for (int r = 0; r < H; r++) begin
            row = '0;
            for (int c = 0; c < W; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0) n += int'(cell_at(bank, r + dr, c + dc));
                row[c] = (n == 3) || (n == 2 && mem[bank][r][c]);
            end
            e.addr = AW'(r);
            e.data = row;
            wq.push_back(e);
        end
    endtask

    task automatic clear_grid();
        for (int r = 0; r < H; r++) begin
            mem[0][r] = '0;
            mem[1][r] = '0;
        end
    endtask

    task automatic set_cell(input int r, input int c);
        mem[bank][r][c] = 1'b1;
    endtask

    // start sampled at cycle 0; the loop counts cycles until done is seen.
    task automatic run_gen(input bit poke_start);
        int n;
        prep_gen();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 1;
        while (!done && n < 4000) begin
            @(negedge clk);
            n++;
            start = poke_start && (n == 500);
        end
        start = 1'b0;
        check("done_cycle", W'(n), W'(2704));
        check("rd_count", W'(rd_exp), W'(H));
        check("wr_left", W'(wq.size()), W'(0));
        if (poke_start) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_gen++;
        check("gen_count", W'(gen_count), W'(exp_gen));
        check("idle_after_done", W'(busy), W'(0));
        bank = 1 - bank;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},  W'(busy), '0);
        check({tag, "_done"},  W'(done), '0);
        check({tag, "_gen"},   W'(gen_count), '0);
        check({tag, "_rden"},  W'(rd_en), '0);
        check({tag, "_rdaddr"}, W'(rd_addr), '0);
        check({tag, "_wren"},  W'(wr_en), '0);
        check({tag, "_wraddr"}, W'(wr_addr), '0);
        check({tag, "_wrdata"}, wr_data, '0);
    endtask

    initial begin
        logic [W-1:0]   exp_row;
        logic [127:0]   rnd;
        n_cmp = 0; n_bad = 0; exp_gen = 0; rd_exp = 0; bank = 0;
        rst_n = 1'b0; start = 1'b0; rd_data = '0;
        clear_grid();
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // Vertical blinker becomes horizontal; a start pulse while busy and at DONE is ignored.
        set_cell(49, 50); set_cell(50, 50); set_cell(51, 50);
        run_gen(1'b1);
        for (int r = 0; r < H; r++) begin
            exp_row = '0;
            if (r == 50) begin
                exp_row[49] = 1'b1; exp_row[50] = 1'b1; exp_row[51] = 1'b1;
            end
            check("blinker_row", mem[bank][r], exp_row);
        end

        // 2x2 block in the top-left corner is a still life.
        clear_grid();
        set_cell(0, 0); set_cell(0, 1); set_cell(1, 0); set_cell(1, 1);
        run_gen(1'b0);
        for (int r = 0; r < 3; r++) begin
            exp_row = '0;
            if (r < 2) begin
                exp_row[0] = 1'b1; exp_row[1] = 1'b1;
            end
            check("corner_row", mem[bank][r], exp_row);
        end

        // All-ones grid leaves only the four corners alive.
        clear_grid();
        for (int r = 0; r < H; r++) mem[bank][r] = '1;
        run_gen(1'b0);
        for (int r = 0; r < H; r++) begin
            exp_row = '0;
            if (r == 0 || r == H - 1) begin
                exp_row[0] = 1'b1; exp_row[W-1] = 1'b1;
            end
            check("allones_row", mem[bank][r], exp_row);
        end

        // Fresh reset, then a glider straddling the col 3/4 block boundary for four generations.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        exp_gen = 0; bank = 0;
        clear_grid();
        set_cell(10, 4); set_cell(11, 5); set_cell(12, 3); set_cell(12, 4); set_cell(12, 5);
        for (int g = 0; g < 4; g++) run_gen(1'b0);
        for (int r = 9; r < 15; r++) begin
            exp_row = '0;
            if (r == 11) exp_row[5] = 1'b1;
            if (r == 12) exp_row[6] = 1'b1;
            if (r == 13) begin
                exp_row[4] = 1'b1; exp_row[5] = 1'b1; exp_row[6] = 1'b1;
            end
            check("glider_row", mem[bank][r], exp_row);
        end

        // Random grid: abort during row 37 SCAN, then a clean rerun.
        for (int r = 0; r < H; r++) begin
            rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
            mem[bank][r] = rnd[W-1:0];
        end
        prep_gen();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (1009) @(posedge clk);
        #2;
        check("abort_busy", W'(busy), W'(1));
        check("abort_rows_left", W'(wq.size()), W'(H - 37));
        rst_n = 1'b0;
        #1;
        check_outputs_zero("abort");
        wq.delete();
        rd_exp = 0;
        exp_gen = 0;
        repeat (3) @(negedge clk);
        check("abort_held_rden", W'(rd_en), '0);
        check("abort_held_wren", W'(wr_en), '0);
        rst_n = 1'b1;
        run_gen(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
